// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Cleans up the four raw paddle push-buttons before they reach the paddle
// logic. Each channel is synchronised with two flops, debounced against a
// tick derived from the 1 ms square wave, and presented as a clean level
// plus single-clock rise/fall pulses.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   When defined, a held button also produces repeat pulses on btn_rise:
//   the first after REPEAT_DELAY_MS ticks, then one every REPEAT_RATE_MS ticks.
//   When undefined, no repeat logic is built.
//
// Parameters
//   DEBOUNCE_MS      ticks a new synced value must hold before acceptance (1..255)
//   REPEAT_DELAY_MS  held ticks before the first repeat pulse (1..1023)
//   REPEAT_RATE_MS   ticks between later repeat pulses (1..1023)
//
// Ports
//   clk       in   1  system clock
//   reset     in   1  synchronous, active-high
//   clk_1ms   in   1  1 ms square wave, sampled as data only
//   btn       in   1  raw button, channel 0
//   btn1      in   1  raw button, channel 1
//   btn2      in   1  raw button, channel 2
//   btn3      in   1  raw button, channel 3
//   btn_lvl   out  4  debounced level, bit i = channel i
//   btn_rise  out  4  1-clk pulse on debounced 0->1 (plus repeat pulses)
//   btn_fall  out  4  1-clk pulse on debounced 1->0
//
// Per-channel FSM state is held in g_ch[i].state for observation.
// -----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int DEBOUNCE_MS     = 10,
   parameter int REPEAT_DELAY_MS = 300,
   parameter int REPEAT_RATE_MS  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1ms,
   input  logic       btn,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   output logic [3:0] btn_lvl,
   output logic [3:0] btn_rise,
   output logic [3:0] btn_fall
);

   localparam logic [1:0] ST_LO      = 2'd0;
   localparam logic [1:0] ST_WAIT_HI = 2'd1;
   localparam logic [1:0] ST_HI      = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   localparam logic [7:0] DEB_LIM = DEBOUNCE_MS[7:0];

   if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_deb
      $error("DEBOUNCE_MS out of range");
   end
   if (REPEAT_DELAY_MS < 1 || REPEAT_DELAY_MS > 1023) begin : g_bad_dly
      $error("REPEAT_DELAY_MS out of range");
   end
   if (REPEAT_RATE_MS < 1 || REPEAT_RATE_MS > 1023) begin : g_bad_rate
      $error("REPEAT_RATE_MS out of range");
   end

   logic [3:0] raw;
   logic [3:0] sync1;
   logic [3:0] s;
   logic       clk_1ms_d;
   logic       tick;

   assign raw = {btn3, btn2, btn1, btn};

   // clk_1ms_d resets high so a clk_1ms already high at release is not
   // mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= 4'b0000;
         s         <= 4'b0000;
         clk_1ms_d <= 1'b1;
         tick      <= 1'b0;
      end else begin
         sync1     <= raw;
         s         <= sync1;
         clk_1ms_d <= clk_1ms;
         tick      <= clk_1ms & ~clk_1ms_d;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic [1:0] state;
      logic [7:0] cnt;
      logic [7:0] cnt_nx;
      logic       lvl;
      logic       rise;
      logic       fall;

      assign cnt_nx = cnt + 8'd1;

`ifdef BTN_AUTOREPEAT_EN
      // rphase=0: counting the initial delay; rphase=1: counting the rate.
      logic [9:0] rcnt;
      logic [9:0] rcnt_nx;
      logic [9:0] rep_lim;
      logic       rphase;

      assign rcnt_nx = rcnt + 10'd1;
      assign rep_lim = rphase ? REPEAT_RATE_MS[9:0] : REPEAT_DELAY_MS[9:0];
`endif

      always_ff @(posedge clk) begin
         if (reset) begin
            state  <= ST_LO;
            cnt    <= 8'd0;
            lvl    <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt   <= 10'd0;
            rphase <= 1'b0;
`endif
         end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
               ST_LO: begin
                  if (s[i]) begin
                     cnt   <= 8'd0;
                     state <= ST_WAIT_HI;
                  end
               end
               // A bounce takes priority over a coincident tick.
               ST_WAIT_HI: begin
                  if (!s[i]) begin
                     state <= ST_LO;
                  end else if (tick) begin
                     cnt <= cnt_nx;
                     if (cnt_nx == DEB_LIM) begin
                        state <= ST_HI;
                        lvl   <= 1'b1;
                        rise  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt   <= 10'd0;
                        rphase <= 1'b0;
`endif
                     end
                  end
               end
               ST_HI: begin
                  if (!s[i]) begin
                     cnt   <= 8'd0;
                     state <= ST_WAIT_LO;
                  end
`ifdef BTN_AUTOREPEAT_EN
                  else if (tick) begin
                     if (rcnt_nx == rep_lim) begin
                        rise   <= 1'b1;
                        rcnt   <= 10'd0;
                        rphase <= 1'b1;
                     end else begin
                        rcnt <= rcnt_nx;
                     end
                  end
`endif
               end
               // Repeat counter is left untouched here, so a return to HI
               // resumes where it stopped.
               ST_WAIT_LO: begin
                  if (s[i]) begin
                     state <= ST_HI;
                  end else if (tick) begin
                     cnt <= cnt_nx;
                     if (cnt_nx == DEB_LIM) begin
                        state <= ST_LO;
                        lvl   <= 1'b0;
                        fall  <= 1'b1;
                     end
                  end
               end
               default: state <= ST_LO;
            endcase
         end
      end

      assign btn_lvl[i]  = lvl;
      assign btn_rise[i] = rise;
      assign btn_fall[i] = fall;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

   localparam int DEB   = 3;
   localparam int RDLY  = 5;
   localparam int RRATE = 2;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_1ms = 1'b1;
   logic       btn = 1'b0, btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
   logic [3:0] btn_lvl, btn_rise, btn_fall;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   btn_conditioner #(
      .DEBOUNCE_MS    (DEB),
      .REPEAT_DELAY_MS(RDLY),
      .REPEAT_RATE_MS (RRATE)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .clk_1ms (clk_1ms),
      .btn     (btn),
      .btn1    (btn1),
      .btn2    (btn2),
      .btn3    (btn3),
      .btn_lvl (btn_lvl),
      .btn_rise(btn_rise),
      .btn_fall(btn_fall)
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   int ms_ph   = 0;   // position inside the 20-clk clk_1ms period
   int cyc     = 0;
   int rise_cnt [4];
   int fall_cnt [4];
   int first_rise [4];

   // ---------------- reference model ----------------
   // Tracks, per channel, how long the synchronised input has disagreed with
   // the accepted level (in ticks) and, while held high, the number of ticks
   // held since acceptance for the repeat schedule.
   logic [3:0] m_s1 = 4'b0, m_s2 = 4'b0;
   logic       m_prev_1ms = 1'b1, m_tick = 1'b0;
   logic [3:0] m_lvl = 4'b0, m_dis = 4'b0, m_rise = 4'b0, m_fall = 4'b0;
   int         m_pend [4];
   int         m_held [4];

   task automatic model_edge(input logic [3:0] b, input logic r, input logic c);
      logic [3:0] s_now;
      logic       tk;
      if (r) begin
         m_s1 = 4'b0; m_s2 = 4'b0; m_prev_1ms = 1'b1; m_tick = 1'b0;
         m_lvl = 4'b0; m_dis = 4'b0; m_rise = 4'b0; m_fall = 4'b0;
         for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_held[i] = 0; end
         return;
      end
      s_now = m_s2;
      tk = m_tick;
      m_rise = 4'b0;
      m_fall = 4'b0;
      for (int i = 0; i < 4; i++) begin
         if (s_now[i] == m_lvl[i]) begin
            // Agreement: a settled high button counts held ticks.
            if (AR && !m_dis[i] && m_lvl[i] && tk) begin
               m_held[i]++;
               if (m_held[i] >= RDLY && ((m_held[i] - RDLY) % RRATE) == 0)
                  m_rise[i] = 1'b1;
            end
            m_dis[i] = 1'b0;
         end else if (!m_dis[i]) begin
            m_dis[i]  = 1'b1;
            m_pend[i] = 0;
         end else if (tk) begin
            m_pend[i]++;
            if (m_pend[i] == DEB) begin
               m_lvl[i] = ~m_lvl[i];
               m_dis[i] = 1'b0;
               if (m_lvl[i]) begin m_rise[i] = 1'b1; m_held[i] = 0; end
               else m_fall[i] = 1'b1;
            end
         end
      end
      m_tick = c & ~m_prev_1ms;
      m_prev_1ms = c;
      m_s2 = m_s1;
      m_s1 = b;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] = 0; fall_cnt[i] = 0; first_rise[i] = -1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [3:0] b, input logic r);
      {btn3, btn2, btn1, btn} = b;
      reset   = r;
      clk_1ms = (ms_ph < 10);
      @(posedge clk);
      model_edge(b, r, clk_1ms);
      ms_ph = (ms_ph == 19) ? 0 : ms_ph + 1;
      cyc++;
      #1;
      check("lvl", btn_lvl, m_lvl);
      check("rise", btn_rise, m_rise);
      check("fall", btn_fall, m_fall);
      check("rise_and_fall", btn_rise & btn_fall, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         if (btn_rise[i]) begin
            rise_cnt[i]++;
            if (first_rise[i] < 0) first_rise[i] = cyc;
         end
         if (btn_fall[i]) fall_cnt[i]++;
      end
   endtask

   task automatic hold(input logic [3:0] b, input int n);
      for (int k = 0; k < n; k++) step(b, 1'b0);
   endtask

   task automatic wait_lvl(input int ch, input logic [3:0] b, input string name);
      int k;
      k = 0;
      while (btn_lvl[ch] !== 1'b1 && k < 120) begin
         step(b, 1'b0);
         k++;
      end
      check_int(name, int'(btn_lvl[ch] === 1'b1), 1);
   endtask

   typedef struct {
      logic [3:0] b;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [3:0] mask, multi, rb;
      int n;

      tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
      tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
      tbl[2] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000};
      tbl[3] = '{4'b0101, 4'b0101, 4'b0101, 4'b1010};
      tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};
      tbl[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
      tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
      clear_counts();

      // Reset held 4 clk with btn=1 and clk_1ms high.
      for (int k = 0; k < 4; k++) begin
         step(4'b0001, 1'b1);
         check("rst_lvl", btn_lvl, 4'b0000);
         check("rst_rise", btn_rise, 4'b0000);
         check("rst_fall", btn_fall, 4'b0000);
      end
      step(4'b0001, 1'b0);
      check("no_tick_after_rst", {3'b000, dut.tick}, 4'b0000);

      // Clean press on channel 0.
      wait_lvl(0, 4'b0001, "accept_ch0");
      check("rise_at_accept", btn_rise & 4'b0001, 4'b0001);
      step(4'b0001, 1'b0);
      check("rise_one_clk", btn_rise & 4'b0001, 4'b0000);
      hold(4'b0000, 80);

      // Table of settled patterns.
      for (int t = 0; t < 7; t++) begin
         clear_counts();
         hold(tbl[t].b, 80);
         check("tbl_lvl", btn_lvl, tbl[t].lvl);
         mask = 4'b0; multi = 4'b0;
         for (int i = 0; i < 4; i++) begin
            mask[i]  = (rise_cnt[i] == 1);
            multi[i] = (rise_cnt[i] > 1) || (fall_cnt[i] > 1);
         end
         check("tbl_rise", mask, tbl[t].rise);
         for (int i = 0; i < 4; i++) mask[i] = (fall_cnt[i] == 1);
         check("tbl_fall", mask, tbl[t].fall);
         check("tbl_multi", multi, 4'b0000);
      end

      // Channel 1 bouncing every 7 clk must never be accepted.
      clear_counts();
      for (int k = 0; k < 100; k++) step((((k / 7) % 2) == 0) ? 4'b0010 : 4'b0000, 1'b0);
      hold(4'b0000, 80);
      check_int("bounce_rise", rise_cnt[1], 0);
      check_int("bounce_fall", fall_cnt[1], 0);
      check("bounce_lvl", btn_lvl, 4'b0000);

      // Channel 2 accepted, 5-clk glitch low ignored, then clean release.
      clear_counts();
      wait_lvl(2, 4'b0100, "accept_ch2");
      hold(4'b0000, 5);
      hold(4'b0100, 40);
      check("glitch_lvl", btn_lvl & 4'b0100, 4'b0100);
      check_int("glitch_fall", fall_cnt[2], 0);
      hold(4'b0000, 80);
      check_int("release_fall", fall_cnt[2], 1);
      check("release_lvl", btn_lvl, 4'b0000);

      // Channels 0 and 3 pressed together.
      clear_counts();
      hold(4'b1001, 80);
      check_int("sim_rise0", rise_cnt[0], 1);
      check_int("sim_rise3", rise_cnt[3], 1);
      check_int("sim_same_clk", first_rise[0], first_rise[3]);
      hold(4'b0000, 80);
      // Reset mid-debounce aborts the press.
      clear_counts();
      hold(4'b1001, 25);
      step(4'b1001, 1'b1);
      check("midrst_lvl", btn_lvl, 4'b0000);
      step(4'b1001, 1'b1);
      hold(4'b0000, 80);
      check_int("midrst_rise0", rise_cnt[0], 0);
      check_int("midrst_rise3", rise_cnt[3], 0);
      check("midrst_lvl_end", btn_lvl, 4'b0000);

      // Channel 1 held 12 ticks after acceptance.
      clear_counts();
      wait_lvl(1, 4'b0010, "accept_ch1");
      check("ar_accept_rise", btn_rise & 4'b0010, 4'b0010);
      clear_counts();
      hold(4'b0010, 12 * 20);
      check_int("ar_repeats", rise_cnt[1], AR ? 4 : 0);
      hold(4'b0000, 80);
      check("ar_release_lvl", btn_lvl, 4'b0000);

      // Randomised segments, checked every clk against the model.
      for (int seg = 0; seg < 60; seg++) begin
         rb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) step(rb, 1'b1);
         end
         hold(rb, $urandom_range(1, 70));
      end
      hold(4'b0000, 80);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #2000000;
      err_cnt++;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
